// File: rtl/stream_stats.sv
// Streaming frame statistics: tracks max, min, sum and count over a valid/ready sample frame
// and presents one result record per frame until the consumer takes it.
module stream_stats #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_max,
    output logic [WIDTH-1:0]       out_min,
    output logic [WIDTH+CNT_W-1:0] out_sum,
    output logic [CNT_W-1:0]       out_cnt,
    output logic                   out_ovf
);

    localparam int SUM_W = WIDTH + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   max_reg;
    logic [WIDTH-1:0]   min_reg;
    logic [SUM_W-1:0]   sum_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ovf_reg;

    logic [SUM_W-1:0]   data_ext;
    logic               accept;
    logic               handoff;
    logic               above_max;
    logic               below_min;
    logic               cnt_full;

    // Upper sum bits replicate the sample MSB only in signed mode.
    assign data_ext[WIDTH-1:0] = in_data;
    generate
        for (genvar gi = WIDTH; gi < SUM_W; gi++) begin : g_ext
            assign data_ext[gi] = SIGNED ? in_data[WIDTH-1] : 1'b0;
        end
    endgenerate

    generate
        if (SIGNED) begin : g_cmp_signed
            assign above_max = $signed(in_data) > $signed(max_reg);
            assign below_min = $signed(in_data) < $signed(min_reg);
        end else begin : g_cmp_unsigned
            assign above_max = in_data > max_reg;
            assign below_min = in_data < min_reg;
        end
    endgenerate

    assign accept   = in_valid & in_ready_reg;
    assign handoff  = out_valid_reg & out_ready;
    assign cnt_full = (cnt_reg == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            max_reg       <= '0;
            min_reg       <= '0;
            sum_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        max_reg <= in_data;
                        min_reg <= in_data;
                        sum_reg <= data_ext;
                        cnt_reg <= CNT_ONE;
                        ovf_reg <= 1'b0;
                        if (in_last) begin
                            state_reg     <= HOLD;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (above_max) max_reg <= in_data;
                        if (below_min) min_reg <= in_data;
                        // Once the count saturates, sum and count freeze; extremes keep tracking.
                        if (!cnt_full) begin
                            sum_reg <= sum_reg + data_ext;
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end else begin
                            ovf_reg <= 1'b1;
                        end
                        if (in_last) begin
                            state_reg     <= HOLD;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (handoff) begin
                        state_reg     <= IDLE;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_max   = max_reg;
    assign out_min   = min_reg;
    assign out_sum   = sum_reg;
    assign out_cnt   = cnt_reg;
    assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_stream_stats.sv
// Three stream_stats configurations (unsigned, signed, 2-bit count) share one input stream
// and are checked against a frame-level reference model plus a table of directed frames.
module tb_stream_stats;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [7:0] in_data;

    logic [2:0] rdy;
    logic [2:0] vld;
    logic [2:0] ov;
    logic [7:0] mx [3];
    logic [7:0] mn [3];
    logic [15:0] sm0, sm1;
    logic [9:0]  sm2;
    logic [7:0]  ct0, ct1;
    logic [1:0]  ct2;

    stream_stats #(.WIDTH(8), .CNT_W(8), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready), .out_max(mx[0]),
        .out_min(mn[0]), .out_sum(sm0), .out_cnt(ct0), .out_ovf(ov[0]));

    stream_stats #(.WIDTH(8), .CNT_W(8), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready), .out_max(mx[1]),
        .out_min(mn[1]), .out_sum(sm1), .out_cnt(ct1), .out_ovf(ov[1]));

    stream_stats #(.WIDTH(8), .CNT_W(2), .SIGNED(1'b0)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
        .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready), .out_max(mx[2]),
        .out_min(mn[2]), .out_sum(sm2), .out_cnt(ct2), .out_ovf(ov[2]));

    int total = 0;
    int bad   = 0;
    int frames_done = 0;

    // Reference model: whole-frame sample list, busy flag, expected record per instance.
    bit         mdl_hold = 1'b0;
    bit         chk_zero = 1'b0;
    logic [7:0] frame_q [$];
    logic [7:0] e_max [3];
    logic [7:0] e_min [3];
    logic [15:0] e_sum [3];
    logic [7:0] e_cnt [3];
    bit         e_ovf [3];

    function automatic int cnt_w(int k);
        return (k == 2) ? 2 : 8;
    endfunction

    function automatic int val(logic [7:0] x, int k);
        if (k == 1) return int'($signed(x));
        return int'(x);
    endfunction

    function automatic logic [15:0] sum_of(int k);
        if (k == 0) return sm0;
        if (k == 1) return sm1;
        return {6'b0, sm2};
    endfunction

    function automatic logic [7:0] cnt_of(int k);
        if (k == 0) return ct0;
        if (k == 1) return ct1;
        return {6'b0, ct2};
    endfunction

    task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
        end
    endtask

    task automatic finish_frame();
        for (int k = 0; k < 3; k++) begin
            int limit, n, cnt, s, mxv, mnv;
            logic [31:0] mask, s32;
            limit = (1 << cnt_w(k)) - 1;
            n = frame_q.size();
            mxv = 0;
            mnv = 0;
            for (int i = 0; i < n; i++) begin
                if (i == 0 || val(frame_q[i], k) > val(frame_q[mxv], k)) mxv = i;
                if (i == 0 || val(frame_q[i], k) < val(frame_q[mnv], k)) mnv = i;
            end
            cnt = (n < limit) ? n : limit;
            s = 0;
            for (int i = 0; i < cnt; i++) s += val(frame_q[i], k);
            mask = (32'd1 << (8 + cnt_w(k))) - 32'd1;
            s32 = 32'(s) & mask;
            e_max[k] = frame_q[mxv];
            e_min[k] = frame_q[mnv];
            e_sum[k] = s32[15:0];
            e_cnt[k] = 8'(cnt);
            e_ovf[k] = (n > limit);
        end
    endtask

    // One clock: apply model to the inputs present before the edge, then compare after it.
    task automatic tick();
        bit r, acc, hand, l;
        logic [7:0] d;
        r = rst;
        acc = in_valid && !mdl_hold;
        hand = out_ready && mdl_hold;
        d = in_data;
        l = in_last;
        @(posedge clk);
        #1;
        chk_zero = 1'b0;
        if (r) begin
            frame_q.delete();
            mdl_hold = 1'b0;
            chk_zero = 1'b1;
        end else if (acc) begin
            frame_q.push_back(d);
            if (l) begin
                finish_frame();
                frame_q.delete();
                mdl_hold = 1'b1;
                frames_done++;
            end
        end else if (hand) begin
            mdl_hold = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            check("in_ready", k, 32'(rdy[k]), 32'(!mdl_hold));
            check("out_valid", k, 32'(vld[k]), 32'(mdl_hold));
            if (mdl_hold) begin
                check("max", k, 32'(mx[k]), 32'(e_max[k]));
                check("min", k, 32'(mn[k]), 32'(e_min[k]));
                check("sum", k, 32'(sum_of(k)), 32'(e_sum[k]));
                check("cnt", k, 32'(cnt_of(k)), 32'(e_cnt[k]));
                check("ovf", k, 32'(ov[k]), 32'(e_ovf[k]));
            end
            if (chk_zero) begin
                check("rst_max", k, 32'(mx[k]), 32'd0);
                check("rst_min", k, 32'(mn[k]), 32'd0);
                check("rst_sum", k, 32'(sum_of(k)), 32'd0);
                check("rst_cnt", k, 32'(cnt_of(k)), 32'd0);
                check("rst_ovf", k, 32'(ov[k]), 32'd0);
            end
        end
    endtask

    typedef struct {
        int          n;
        logic [7:0]  s [5];
        int          k;
        logic [7:0]  mx;
        logic [7:0]  mn;
        logic [15:0] sm;
        logic [7:0]  ct;
        bit          ov;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int guard;
        tbl[0].n = 4; tbl[0].s = '{8'd5, 8'd200, 8'd17, 8'd200, 8'd0}; tbl[0].k = 0;
        tbl[0].mx = 8'd200; tbl[0].mn = 8'd5; tbl[0].sm = 16'd422; tbl[0].ct = 8'd4; tbl[0].ov = 1'b0;
        tbl[1].n = 3; tbl[1].s = '{8'hF6, 8'h03, 8'h80, 8'h00, 8'h00}; tbl[1].k = 1;
        tbl[1].mx = 8'h03; tbl[1].mn = 8'h80; tbl[1].sm = 16'hFF79; tbl[1].ct = 8'd3; tbl[1].ov = 1'b0;
        tbl[2].n = 5; tbl[2].s = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1}; tbl[2].k = 2;
        tbl[2].mx = 8'd1; tbl[2].mn = 8'd1; tbl[2].sm = 16'd3; tbl[2].ct = 8'd3; tbl[2].ov = 1'b1;
        tbl[3].n = 1; tbl[3].s = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h00}; tbl[3].k = 0;
        tbl[3].mx = 8'h42; tbl[3].mn = 8'h42; tbl[3].sm = 16'h0042; tbl[3].ct = 8'd1; tbl[3].ov = 1'b0;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed frames: stream, check record, hold it 3 cycles unread, then hand off.
        for (int t = 0; t < 4; t++) begin
            out_ready = 1'b0;
            for (int i = 0; i < tbl[t].n; i++) begin
                in_valid = 1'b1;
                in_data  = tbl[t].s[i];
                in_last  = (i == tbl[t].n - 1);
                tick();
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            check("tbl_valid", tbl[t].k, 32'(vld[tbl[t].k]), 32'd1);
            check("tbl_max", tbl[t].k, 32'(mx[tbl[t].k]), 32'(tbl[t].mx));
            check("tbl_min", tbl[t].k, 32'(mn[tbl[t].k]), 32'(tbl[t].mn));
            check("tbl_sum", tbl[t].k, 32'(sum_of(tbl[t].k)), 32'(tbl[t].sm));
            check("tbl_cnt", tbl[t].k, 32'(cnt_of(tbl[t].k)), 32'(tbl[t].ct));
            check("tbl_ovf", tbl[t].k, 32'(ov[tbl[t].k]), 32'(tbl[t].ov));
            tick();
            tick();
            tick();
            check("hold_max", tbl[t].k, 32'(mx[tbl[t].k]), 32'(tbl[t].mx));
            check("hold_ready", tbl[t].k, 32'(rdy[tbl[t].k]), 32'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            tick();
        end

        // Single sample with the consumer already ready: one valid cycle, then ready again.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h42; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("single_valid", 0, 32'(vld[0]), 32'd1);
        check("single_sum", 0, 32'(sm0), 32'h42);
        tick();
        check("single_ready_after", 0, 32'(rdy[0]), 32'd1);
        out_ready = 1'b0;

        // Reset in the middle of a frame discards it.
        in_valid = 1'b1; in_last = 1'b0; in_data = 8'd7;
        tick();
        in_data = 8'd8;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'd9; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("post_rst_cnt", 0, 32'(ct0), 32'd1);
        check("post_rst_sum", 0, 32'(sm0), 32'd9);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Random traffic: gaps on both sides, junk presented while a record is held.
        frames_done = 0;
        guard = 0;
        while (frames_done < 1000 && guard < 60000) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 99) < 50);
            tick();
            guard++;
        end
        check("rand_frames_done", 0, 32'(frames_done >= 1000), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
